semaphore_monitor: RTL and testbench
====================================

// Module: semaphore_monitor
// PURPOSE
//   Safety monitor downstream of the two-way semaphore light controller. Samples the six
//   lamp outputs and the 1-second tick. Checks lamp patterns, phase order and phase dwell
//   times. Latches the first fault with a code and drives a fail-safe flashing-yellow request.
// PARAMETERS
//   GREEN_SECS   30  nominal green dwell, in ticks
//   YELLOW_SECS  3   nominal yellow dwell, in ticks
//   TOL_SECS     1   allowed +/- deviation on any dwell, in ticks
// PORTS
//   clk           in   1  system clock; all state changes on its rising edge
//   rst           in   1  asynchronous active-low reset (0 = reset)
//   clk_seconds   in   1  one-cycle tick, once per second
//   green1..red2  in   1  six lamp inputs: green1, yellow1, red1, green2, yellow2, red2
//   fault_ack     in   1  one-cycle pulse that clears a latched fault
//   fault         out  1  latched fault flag
//   fault_code    out  3  0 none, 1 ILLEGAL, 2 SEQUENCE, 3 SHORT, 4 LONG
//   phase         out  2  0 INIT, 1 YEL, 2 GRN1, 3 GRN2 (holds its last value in FAULT)
//   phase_secs    out  8  ticks elapsed in the current phase; saturates at 255
//   flash_yellow  out  1  fail-safe blink request
// BEHAVIOUR
//   - Reset (rst=0, asynchronous): every output = 0, FSM in INIT, last_green = none.
//   - All outputs are registered. A fault is visible 1 clk after the edge that samples the offending input.
//   - Lamp inputs decode to a pattern each cycle:
//       OFF = all six 0
//       Y   = yellow1 & yellow2 only
//       G1  = green1 & red2 only
//       G2  = green2 & red1 only
//       any other combination = ILLEGAL
//   - FSM states: INIT, YEL, GRN1, GRN2, FAULT.
//   - INIT:
//       OFF    -> stay in INIT
//       Y/G1/G2 -> enter YEL/GRN1/GRN2; this first phase is exempt from the SHORT check
//       ILLEGAL -> FAULT, code 1
//   - Legal order is Y->G1->Y->G2->Y->G1... A yellow phase must be followed by the opposite
//     green to last_green; when last_green = none, either green is accepted.
//   - Order violation (including G1<->G2 with no Y between, or a return to OFF) -> FAULT, code 2.
//   - ILLEGAL pattern in any non-FAULT state -> FAULT, code 1.
//   - phase_secs: +1 on each clk_seconds while the pattern is unchanged.
//       On a pattern change it loads 0, or 1 if clk_seconds is high in the same cycle.
//   - On a phase change the old phase_secs is the dwell D. Nominal N = GREEN_SECS or YELLOW_SECS.
//       D < N-TOL  -> FAULT, code 3 (skipped for the first phase after INIT)
//   - Overrun is checked on each tick while the pattern is unchanged:
//       incremented phase_secs > N+TOL -> FAULT, code 4; do not wait for the phase to change.
//   - Fault priority when several apply in one cycle: 1 > 2 > 3 > 4.
//   - FAULT state:
//       fault=1; only the first code is kept and later faults are ignored.
//       phase and phase_secs freeze.
//       flash_yellow toggles on every clk_seconds; it is 0 in all other states.
//   - fault_ack=1 in FAULT -> INIT next edge: fault=0, code=0, flash_yellow=0, phase_secs=0,
//     last_green=none. If the inputs are still illegal, the fault is re-raised 1 cycle later.
//   - fault_ack outside FAULT is ignored. fault_ack wins over a fault detected in the same cycle.
//   - Reset asserted mid-phase or mid-fault: immediate return to reset values.
// TESTING (bench uses GREEN_SECS=5, YELLOW_SECS=2, TOL_SECS=0, tick every 10 clk)
//   1. Drive Y 2 ticks, G1 5, Y 2, G2 5, repeated 3 times -> fault stays 0;
//      phase goes 1,2,1,3,...; phase_secs peaks at 5 in green.
//   2. Drive green1=green2=1 while in GRN1 -> next cycle fault=1, code=1;
//      flash_yellow toggles at each tick; phase stays 2.
//   3. Drive Y->G1->Y->G1 -> code=2 on the second G1 entry. Drive G1->G2 directly -> code=2.
//   4. Drive G1 for only 3 ticks, then Y -> code=3.
//      Hold Y past 2 ticks -> code=4 on the 3rd tick with phase_secs=2.
//   5. Pulse fault_ack in FAULT with legal inputs -> fault=0, code=0, phase=0, then tracking resumes.
//      Pulse fault_ack together with ILLEGAL inputs -> re-fault 1 cycle later.
//   6. Pull rst=0 mid-green and mid-fault -> all outputs 0 without waiting for clk.
//      Hold a pattern for 300 ticks with a large GREEN_SECS -> phase_secs saturates at 255.

Source files
------------

// File: rtl/semaphore_monitor_if.sv
// Lamp, tick and acknowledge inputs plus the fault/phase status outputs of the semaphore monitor.
// The master side is the light controller (or bench); the monitor is the slave.
interface semaphore_monitor_if;
    logic       clk_seconds;
    logic       green1;
    logic       yellow1;
    logic       red1;
    logic       green2;
    logic       yellow2;
    logic       red2;
    logic       fault_ack;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] phase;
    logic [7:0] phase_secs;
    logic       flash_yellow;

    modport master (
        output clk_seconds, green1, yellow1, red1, green2, yellow2, red2, fault_ack,
        input  fault, fault_code, phase, phase_secs, flash_yellow
    );

    modport slave (
        input  clk_seconds, green1, yellow1, red1, green2, yellow2, red2, fault_ack,
        output fault, fault_code, phase, phase_secs, flash_yellow
    );
endinterface

// File: rtl/semaphore_monitor.sv
// Safety monitor for a two-way semaphore: checks lamp patterns, phase order and dwell times,
// latches the first fault with a code and requests a flashing-yellow fail-safe.
module semaphore_monitor #(
    parameter int GREEN_SECS  = 30,
    parameter int YELLOW_SECS = 3,
    parameter int TOL_SECS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    semaphore_monitor_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_YEL   = 3'd1,
        ST_GRN1  = 3'd2,
        ST_GRN2  = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Pattern codes 0..3 deliberately match the phase encoding and tracking state codes.
    typedef enum logic [2:0] {
        PAT_OFF = 3'd0,
        PAT_Y   = 3'd1,
        PAT_G1  = 3'd2,
        PAT_G2  = 3'd3,
        PAT_ILL = 3'd4
    } pat_e;

    typedef enum logic [1:0] {
        LG_NONE = 2'd0,
        LG_G1   = 2'd1,
        LG_G2   = 2'd2
    } last_e;

    localparam int GRN_MIN = GREEN_SECS - TOL_SECS;
    localparam int GRN_MAX = GREEN_SECS + TOL_SECS;
    localparam int YEL_MIN = YELLOW_SECS - TOL_SECS;
    localparam int YEL_MAX = YELLOW_SECS + TOL_SECS;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd1;
    localparam logic [2:0] CODE_SEQUENCE = 3'd2;
    localparam logic [2:0] CODE_SHORT    = 3'd3;
    localparam logic [2:0] CODE_LONG     = 3'd4;

    state_e      state_q, state_d;
    last_e       last_green_q, last_green_d;
    logic        first_q, first_d;
    logic [1:0]  phase_q, phase_d;
    logic [7:0]  phase_secs_q, phase_secs_d;
    logic        fault_q, fault_d;
    logic [2:0]  fault_code_q, fault_code_d;
    logic        flash_q, flash_d;

    logic [5:0]  lamps_s;
    pat_e        pat_s;
    pat_e        cur_pat_s;
    int          dwell_min_s;
    int          dwell_max_s;
    logic        order_ok_s;
    logic [8:0]  secs_inc_s;
    logic [7:0]  secs_sat_s;
    logic        short_s;
    logic        long_s;
    logic [2:0]  raise_s;

    assign lamps_s    = {bus.green1, bus.yellow1, bus.red1, bus.green2, bus.yellow2, bus.red2};
    assign secs_inc_s = {1'b0, phase_secs_q} + 9'd1;
    assign secs_sat_s = secs_inc_s[8] ? 8'hFF : secs_inc_s[7:0];
    assign short_s    = (int'(phase_secs_q) < dwell_min_s);
    assign long_s     = (int'(secs_inc_s) > dwell_max_s);

    // Decode the six lamps into one of the four legal patterns or ILLEGAL.
    always_comb begin
        pat_s = PAT_ILL;
        case (lamps_s)
            6'b000000: pat_s = PAT_OFF;
            6'b010010: pat_s = PAT_Y;
            6'b100001: pat_s = PAT_G1;
            6'b001100: pat_s = PAT_G2;
            default:   pat_s = PAT_ILL;
        endcase
    end

    // Per-state expected pattern, dwell window and allowed successor pattern.
    always_comb begin
        cur_pat_s   = PAT_OFF;
        dwell_min_s = GRN_MIN;
        dwell_max_s = GRN_MAX;
        order_ok_s  = 1'b0;
        case (state_q)
            ST_INIT: begin
                cur_pat_s  = PAT_OFF;
                order_ok_s = (pat_s == PAT_Y) || (pat_s == PAT_G1) || (pat_s == PAT_G2);
            end
            ST_YEL: begin
                cur_pat_s   = PAT_Y;
                dwell_min_s = YEL_MIN;
                dwell_max_s = YEL_MAX;
                order_ok_s  = ((pat_s == PAT_G1) && (last_green_q != LG_G1)) ||
                              ((pat_s == PAT_G2) && (last_green_q != LG_G2));
            end
            ST_GRN1: begin
                cur_pat_s  = PAT_G1;
                order_ok_s = (pat_s == PAT_Y);
            end
            ST_GRN2: begin
                cur_pat_s  = PAT_G2;
                order_ok_s = (pat_s == PAT_Y);
            end
            default: begin
                cur_pat_s  = PAT_OFF;
                order_ok_s = 1'b0;
            end
        endcase
    end

    // Next-state logic: phase tracking, fault detection by priority, fault hold and acknowledge.
    always_comb begin
        state_d      = state_q;
        last_green_d = last_green_q;
        first_d      = first_q;
        phase_d      = phase_q;
        phase_secs_d = phase_secs_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        flash_d      = flash_q;
        raise_s      = CODE_NONE;
        case (state_q)
            ST_FAULT: begin
                if (bus.fault_ack) begin
                    state_d      = ST_INIT;
                    last_green_d = LG_NONE;
                    first_d      = 1'b0;
                    phase_d      = 2'd0;
                    phase_secs_d = 8'd0;
                    fault_d      = 1'b0;
                    fault_code_d = CODE_NONE;
                    flash_d      = 1'b0;
                end else if (bus.clk_seconds) begin
                    flash_d = ~flash_q;
                end else begin
                    flash_d = flash_q;
                end
            end
            default: begin
                if (pat_s == PAT_ILL) begin
                    raise_s = CODE_ILLEGAL;
                end else if (pat_s != cur_pat_s) begin
                    if (!order_ok_s) begin
                        raise_s = CODE_SEQUENCE;
                    end else if ((state_q != ST_INIT) && !first_q && short_s) begin
                        raise_s = CODE_SHORT;
                    end else begin
                        state_d      = state_e'({1'b0, pat_s[1:0]});
                        phase_d      = pat_s[1:0];
                        phase_secs_d = bus.clk_seconds ? 8'd1 : 8'd0;
                        first_d      = (state_q == ST_INIT);
                        if (pat_s == PAT_G1) begin
                            last_green_d = LG_G1;
                        end else if (pat_s == PAT_G2) begin
                            last_green_d = LG_G2;
                        end else begin
                            last_green_d = last_green_q;
                        end
                    end
                end else if (bus.clk_seconds) begin
                    // Overrun is flagged on the tick itself; the dwell shown stays at its last value.
                    if ((state_q != ST_INIT) && long_s) begin
                        raise_s = CODE_LONG;
                    end else begin
                        phase_secs_d = secs_sat_s;
                    end
                end else begin
                    phase_secs_d = phase_secs_q;
                end

                if (raise_s != CODE_NONE) begin
                    state_d      = ST_FAULT;
                    phase_d      = phase_q;
                    phase_secs_d = phase_secs_q;
                    fault_d      = 1'b1;
                    fault_code_d = raise_s;
                end else begin
                    fault_d = fault_q;
                end
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_INIT;
            last_green_q <= LG_NONE;
            first_q      <= 1'b0;
            phase_q      <= 2'd0;
            phase_secs_q <= 8'd0;
            fault_q      <= 1'b0;
            fault_code_q <= 3'd0;
            flash_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_green_q <= last_green_d;
            first_q      <= first_d;
            phase_q      <= phase_d;
            phase_secs_q <= phase_secs_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            flash_q      <= flash_d;
        end
    end

    assign bus.fault        = fault_q;
    assign bus.fault_code   = fault_code_q;
    assign bus.phase        = phase_q;
    assign bus.phase_secs   = phase_secs_q;
    assign bus.flash_yellow = flash_q;
endmodule

// File: tb/tb_semaphore_monitor.sv
// Directed plus randomized bench for semaphore_monitor against a pattern-level reference model.
// A second instance with a very long green dwell is held in green to exercise saturation.
module tb_semaphore_monitor;
    localparam int G_S   = 5;
    localparam int Y_S   = 2;
    localparam int T_S   = 0;
    localparam int G_SAT = 400;

    localparam int P_OFF = 0;
    localparam int P_Y   = 1;
    localparam int P_G1  = 2;
    localparam int P_G2  = 3;
    localparam int P_ILL = 4;

    // Lamp order: {green1, yellow1, red1, green2, yellow2, red2}
    localparam logic [5:0] L_OFF = 6'b000000;
    localparam logic [5:0] L_Y   = 6'b010010;
    localparam logic [5:0] L_G1  = 6'b100001;
    localparam logic [5:0] L_G2  = 6'b001100;
    localparam logic [5:0] L_ILL = 6'b100100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   tcnt = 0;

    semaphore_monitor_if bus();
    semaphore_monitor_if bus_sat();

    semaphore_monitor #(.GREEN_SECS(G_S), .YELLOW_SECS(Y_S), .TOL_SECS(T_S)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    semaphore_monitor #(.GREEN_SECS(G_SAT), .YELLOW_SECS(Y_S), .TOL_SECS(T_S)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_sat)
    );

    always #5 clk = ~clk;

    // Reference model state per instance; the current pattern doubles as the phase value.
    int m_cur[2], m_secs[2], m_last[2], m_code[2];
    bit m_first[2], m_fault[2], m_flash[2];

    // Scenario-1 observation.
    bit rec = 1'b0;
    int rec_last = 0;
    int max_secs = 0;
    int seen_phases[$];

    function automatic int classify(input logic [5:0] v);
        case (v)
            L_OFF:   return P_OFF;
            L_Y:     return P_Y;
            L_G1:    return P_G1;
            L_G2:    return P_G2;
            default: return P_ILL;
        endcase
    endfunction

    function automatic bit legal_next(input int cur, input int last, input int p);
        if (cur == P_OFF) return (p == P_Y) || (p == P_G1) || (p == P_G2);
        if (cur == P_Y)   return ((p == P_G1) || (p == P_G2)) && (p != last);
        return p == P_Y;
    endfunction

    function automatic void model_clear(input int k);
        m_cur[k] = 0; m_secs[k] = 0; m_last[k] = 0; m_code[k] = 0;
        m_first[k] = 1'b0; m_fault[k] = 1'b0; m_flash[k] = 1'b0;
    endfunction

    function automatic void model_step(input int k, input int p, input bit tick, input bit ack);
        int nom, code;
        bit ill, changed, seq_bad, short_bad, long_bad;
        if (m_fault[k]) begin
            if (ack) model_clear(k);
            else if (tick) m_flash[k] = !m_flash[k];
            return;
        end
        nom       = (m_cur[k] == P_Y) ? Y_S : ((k == 0) ? G_S : G_SAT);
        ill       = (p == P_ILL);
        changed   = !ill && (p != m_cur[k]);
        seq_bad   = changed && !legal_next(m_cur[k], m_last[k], p);
        short_bad = changed && (m_cur[k] != P_OFF) && !m_first[k] && (m_secs[k] < nom - T_S);
        long_bad  = !ill && !changed && tick && (m_cur[k] != P_OFF) && (m_secs[k] + 1 > nom + T_S);
        code = ill ? 1 : seq_bad ? 2 : short_bad ? 3 : long_bad ? 4 : 0;
        if (code != 0) begin
            m_fault[k] = 1'b1;
            m_code[k]  = code;
        end else if (changed) begin
            m_first[k] = (m_cur[k] == P_OFF);
            if (p >= P_G1) m_last[k] = p;
            m_cur[k]  = p;
            m_secs[k] = tick ? 1 : 0;
        end else if (tick && m_secs[k] < 255) begin
            m_secs[k] = m_secs[k] + 1;
        end
    endfunction

    function automatic logic [14:0] obs(input int k);
        if (k == 0) return {bus.fault, bus.fault_code, bus.phase, bus.phase_secs, bus.flash_yellow};
        return {bus_sat.fault, bus_sat.fault_code, bus_sat.phase, bus_sat.phase_secs, bus_sat.flash_yellow};
    endfunction

    function automatic logic [14:0] expv(input int k);
        return {m_fault[k], 3'(m_code[k]), 2'(m_cur[k]), 8'(m_secs[k]), m_flash[k]};
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 2; k++) begin
            logic [14:0] got, want;
            got  = obs(k);
            want = expv(k);
            vectors++;
            assert (got === want) else begin
                miscompares++;
                $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, got, want);
            end
        end
    endtask

    task automatic chk(input string tag, input int got, input int want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic cycle(input logic [5:0] lamps, input bit ack);
        bit tk;
        tk   = (tcnt == 9);
        tcnt = (tcnt + 1) % 10;
        {bus.green1, bus.yellow1, bus.red1, bus.green2, bus.yellow2, bus.red2} = lamps;
        bus.clk_seconds = tk;
        bus.fault_ack   = ack;
        {bus_sat.green1, bus_sat.yellow1, bus_sat.red1,
         bus_sat.green2, bus_sat.yellow2, bus_sat.red2} = L_G1;
        bus_sat.clk_seconds = tk;
        bus_sat.fault_ack   = 1'b0;
        @(posedge clk);
        model_step(0, classify(lamps), tk, ack);
        model_step(1, P_G1, tk, 1'b0);
        #1;
        check_all("cycle");
        if (rec) begin
            if (int'(bus.phase) != rec_last) begin
                rec_last = int'(bus.phase);
                seen_phases.push_back(rec_last);
            end
            if (bus.phase >= 2'd2 && int'(bus.phase_secs) > max_secs) max_secs = int'(bus.phase_secs);
        end
    endtask

    task automatic hold(input logic [5:0] lamps, input int n_ticks);
        repeat (10 * n_ticks) cycle(lamps, 1'b0);
    endtask

    task automatic align(input logic [5:0] lamps);
        while (tcnt != 0) cycle(lamps, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        model_clear(0);
        model_clear(1);
        check_all(tag);
        chk({tag, "_fault"}, bus.fault, 0);
        @(negedge clk);
        rst  = 1'b1;
        tcnt = 0;
    endtask

    initial begin
        logic [5:0] lamp_tab [4];
        int exp_ph [4];
        lamp_tab = '{L_OFF, L_Y, L_G1, L_G2};
        exp_ph   = '{1, 2, 1, 3};

        {bus.green1, bus.yellow1, bus.red1, bus.green2, bus.yellow2, bus.red2} = L_OFF;
        bus.clk_seconds = 1'b0; bus.fault_ack = 1'b0;
        {bus_sat.green1, bus_sat.yellow1, bus_sat.red1,
         bus_sat.green2, bus_sat.yellow2, bus_sat.red2} = L_OFF;
        bus_sat.clk_seconds = 1'b0; bus_sat.fault_ack = 1'b0;
        model_clear(0);
        model_clear(1);
        #1;
        check_all("reset");
        repeat (2) @(negedge clk);
        rst  = 1'b1;
        tcnt = 0;

        // 1: three nominal cycles Y2 G1 5 Y2 G2 5
        hold(L_OFF, 1);
        rec = 1'b1;
        repeat (3) begin
            hold(L_Y, 2); hold(L_G1, 5); hold(L_Y, 2); hold(L_G2, 5);
        end
        rec = 1'b0;
        chk("s1_fault", bus.fault, 0);
        chk("s1_peak", max_secs, 5);
        chk("s1_nphase", seen_phases.size(), 12);
        for (int i = 0; i < seen_phases.size() && i < 12; i++) chk("s1_phase", seen_phases[i], exp_ph[i % 4]);

        // 2: both greens while in GRN1
        hold(L_Y, 2); hold(L_G1, 2);
        cycle(L_ILL, 1'b0);
        chk("s2_fault", bus.fault, 1);
        chk("s2_code", bus.fault_code, 1);
        chk("s2_phase", bus.phase, 2);
        repeat (9) cycle(L_ILL, 1'b0);
        chk("s2_flash1", bus.flash_yellow, 1);
        repeat (10) cycle(L_ILL, 1'b0);
        chk("s2_flash0", bus.flash_yellow, 0);
        chk("s2_secs", bus.phase_secs, 2);

        // 5a: acknowledge with legal inputs, tracking resumes
        cycle(L_Y, 1'b1);
        chk("s5_ack_fault", bus.fault, 0);
        chk("s5_ack_code", bus.fault_code, 0);
        chk("s5_ack_phase", bus.phase, 0);
        cycle(L_Y, 1'b0);
        chk("s5_resume_phase", bus.phase, 1);
        align(L_Y);

        // 3: Y->G1->Y->G1, then G1->G2 directly
        hold(L_Y, 1); hold(L_G1, 5); hold(L_Y, 2);
        cycle(L_G1, 1'b0);
        chk("s3_seq1_code", bus.fault_code, 2);
        chk("s3_seq1_phase", bus.phase, 1);
        cycle(L_OFF, 1'b1); align(L_OFF);
        hold(L_G1, 5);
        cycle(L_G2, 1'b0);
        chk("s3_seq2_code", bus.fault_code, 2);

        // 4: short green, then overlong yellow
        cycle(L_OFF, 1'b1); align(L_OFF);
        hold(L_Y, 2); hold(L_G1, 3);
        cycle(L_Y, 1'b0);
        chk("s4_short_code", bus.fault_code, 3);
        chk("s4_short_secs", bus.phase_secs, 3);
        cycle(L_OFF, 1'b1); align(L_OFF);
        hold(L_Y, 2);
        repeat (10) cycle(L_Y, 1'b0);
        chk("s4_long_code", bus.fault_code, 4);
        chk("s4_long_secs", bus.phase_secs, 2);

        // 5b: acknowledge while inputs are still illegal
        cycle(L_ILL, 1'b1);
        chk("s5_illack_fault", bus.fault, 0);
        cycle(L_ILL, 1'b0);
        chk("s5_refault", bus.fault, 1);
        chk("s5_refault_code", bus.fault_code, 1);

        // 6: asynchronous reset mid-green and mid-fault
        cycle(L_OFF, 1'b1); align(L_OFF);
        hold(L_G1, 2);
        async_reset("rst_mid_green");
        cycle(L_ILL, 1'b0);
        repeat (3) cycle(L_ILL, 1'b0);
        async_reset("rst_mid_fault");

        // Randomized segments: mostly legal successions with random dwell, some bad patterns.
        for (int s = 0; s < 200; s++) begin
            int r, len, nxt;
            logic [5:0] lv;
            r   = int'($urandom_range(0, 99));
            len = int'($urandom_range(5, 70));
            if (r < 70) begin
                if (m_cur[0] == P_Y)
                    nxt = (m_last[0] == P_G1) ? P_G2 : (m_last[0] == P_G2) ? P_G1 : int'($urandom_range(2, 3));
                else if (m_cur[0] == P_OFF)
                    nxt = int'($urandom_range(1, 3));
                else
                    nxt = P_Y;
                lv = lamp_tab[nxt];
            end else if (r < 90) begin
                lv = lamp_tab[$urandom_range(0, 3)];
            end else begin
                lv = 6'($urandom);
                while (classify(lv) != P_ILL) lv = 6'($urandom);
            end
            repeat (len) cycle(lv, ($urandom_range(0, 29) == 0));
        end

        // Saturation on the long-green instance.
        cycle(L_OFF, 1'b1);
        repeat (3000) cycle(L_OFF, 1'b0);
        chk("sat_secs", bus_sat.phase_secs, 255);
        chk("sat_phase", bus_sat.phase, 2);
        chk("sat_fault", bus_sat.fault, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
